// File: rtl/mem_stage_if.sv
// mem_stage_if: execute/SRAM/write-back handshake and bus bundle around the memory stage.
interface mem_stage_if;
    logic        ex_mem_valid;
    logic [73:0] ex_mem_bus;
    logic        mem_allowin;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_wb_valid;
    logic        wb_allowin;
    logic [69:0] mem_wb_bus;
    logic [38:0] mem_id_bus;

    modport master (
        output ex_mem_valid, ex_mem_bus, data_sram_data_ok, data_sram_rdata, wb_allowin,
        input  mem_allowin, mem_wb_valid, mem_wb_bus, mem_id_bus
    );

    modport slave (
        input  ex_mem_valid, ex_mem_bus, data_sram_data_ok, data_sram_rdata, wb_allowin,
        output mem_allowin, mem_wb_valid, mem_wb_bus, mem_id_bus
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; waits for load data, aligns/extends it, buffers across write-back stalls.
module mem_stage (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave mif
);
    typedef enum logic [1:0] {PASS, WAIT, HOLD} state_t;

    state_t      state, state_nx;
    logic        mem_valid, mem_ready_go, allowin, accept;
    logic [73:0] bus_r;
    logic [31:0] rdata_buf, ld_word, ld_val, final_result;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        gr_we, res_from_mem;
    logic [2:0]  ld_type;
    logic [4:0]  dest;
    logic [31:0] pc, alu_result;

    assign {gr_we, res_from_mem, ld_type, dest, pc, alu_result} = bus_r;

    assign mem_ready_go = (state == WAIT) ? mif.data_sram_data_ok : 1'b1;
    assign allowin      = ~mem_valid | (mem_ready_go & mif.wb_allowin);
    assign accept       = mif.ex_mem_valid & allowin;

    // A retiring slot is refilled or drained; only an unretired WAIT can move to HOLD.
    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = mif.ex_mem_bus[72] ? WAIT : PASS;
        else if (allowin)
            state_nx = PASS;
        else if (state == WAIT && mif.data_sram_data_ok)
            state_nx = HOLD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= PASS;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
            bus_r     <= '0;
            rdata_buf <= '0;
        end else begin
            if (accept) begin
                mem_valid <= 1'b1;
                bus_r     <= mif.ex_mem_bus;
            end else if (allowin) begin
                mem_valid <= 1'b0;
            end
            if (state == WAIT && mif.data_sram_data_ok && !allowin)
                rdata_buf <= mif.data_sram_rdata;
        end
    end

    assign ld_word = (state == HOLD) ? rdata_buf : mif.data_sram_rdata;

    always_comb begin
        ld_byte = (alu_result[1:0] == 2'd0) ? ld_word[7:0]   :
                  (alu_result[1:0] == 2'd1) ? ld_word[15:8]  :
                  (alu_result[1:0] == 2'd2) ? ld_word[23:16] : ld_word[31:24];
        ld_half = alu_result[1] ? ld_word[31:16] : ld_word[15:0];
        ld_val  = (ld_type == 3'd1) ? {{24{ld_byte[7]}}, ld_byte} :
                  (ld_type == 3'd2) ? {{16{ld_half[15]}}, ld_half} :
                  (ld_type == 3'd3) ? {24'd0, ld_byte} :
                  (ld_type == 3'd4) ? {16'd0, ld_half} : ld_word;
        final_result = res_from_mem ? ld_val : alu_result;
    end

    assign mif.mem_allowin  = allowin;
    assign mif.mem_wb_valid = mem_valid & mem_ready_go;
    assign mif.mem_wb_bus   = {gr_we, dest, pc, final_result};
    assign mif.mem_id_bus   = {mem_valid & gr_we, mem_valid & res_from_mem & ~mem_ready_go, dest, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed literal checks plus randomized traffic against a transaction-level model of the stage.
module tb_mem_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if mif();
    mem_stage dut (.clk(clk), .reset(reset), .mif(mif));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [73:0] mk(input logic we, input logic rfm, input logic [2:0] ld,
                                       input logic [4:0] d, input logic [31:0] pc, input logic [31:0] alu);
        return {we, rfm, ld, d, pc, alu};
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] ld, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> (8 * int'(a));
        b = sh[7:0];
        h = a[1] ? w[31:16] : w[15:0];
        case (ld)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {{16{h[15]}}, h};
            3'd3:    return {24'd0, b};
            3'd4:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Model: one slot holding the current instruction and, for loads, whether its data has arrived.
    logic        m_v, m_have;
    logic [73:0] m_bus;
    logic [31:0] m_held;
    logic        m_ld, e_ready, e_allow;
    logic [31:0] e_final;

    always_comb begin
        m_ld    = m_bus[72];
        e_ready = m_v & (!m_ld | m_have | mif.data_sram_data_ok);
        e_allow = !m_v | (e_ready & mif.wb_allowin);
        e_final = m_ld ? ext(m_bus[71:69], m_bus[1:0], m_have ? m_held : mif.data_sram_rdata) : m_bus[31:0];
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_v    <= 1'b0;
            m_have <= 1'b0;
            m_bus  <= '0;
            m_held <= '0;
        end else if (mif.ex_mem_valid && e_allow) begin
            m_v    <= 1'b1;
            m_bus  <= mif.ex_mem_bus;
            m_have <= 1'b0;
        end else if (e_allow) begin
            m_v <= 1'b0;
        end else if (m_ld && !m_have && mif.data_sram_data_ok) begin
            m_have <= 1'b1;
            m_held <= mif.data_sram_rdata;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("wb_valid", mif.mem_wb_valid, e_ready);
            chk("allowin", mif.mem_allowin, e_allow);
            chk("id_flags", mif.mem_id_bus[38:37], {m_v & m_bus[73], m_v & m_ld & !e_ready});
            if (e_ready) chk("wb_bus", mif.mem_wb_bus, {m_bus[73], m_bus[68:64], m_bus[63:32], e_final});
            if (m_v) chk("id_data", mif.mem_id_bus[36:0], {m_bus[68:64], e_final});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string name, input logic [2:0] ld, input logic [31:0] alu,
                           input logic [31:0] rd, input logic [31:0] exp);
        mif.ex_mem_valid = 1'b1;
        mif.ex_mem_bus   = mk(1'b1, 1'b1, ld, 5'd4, 32'h400, alu);
        step();
        mif.ex_mem_valid      = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = rd;
        #3;
        chk({name, "_valid"}, mif.mem_wb_valid, 1'b1);
        chk({name, "_res"}, mif.mem_wb_bus[31:0], exp);
        step();
        mif.data_sram_data_ok = 1'b0;
    endtask

    logic [31:0] alu_vals [3] = '{32'h11, 32'h22, 32'h33};
    logic [69:0] hold_bus;

    initial begin
        mif.ex_mem_valid      = 1'b0;
        mif.ex_mem_bus        = '0;
        mif.data_sram_data_ok = 1'b0;
        mif.data_sram_rdata   = '0;
        mif.wb_allowin        = 1'b1;
        #1 reset = 1'b1;
        #2;
        chk("rst_wb_valid", mif.mem_wb_valid, 1'b0);
        chk("rst_allowin", mif.mem_allowin, 1'b1);
        chk("rst_wb_bus", mif.mem_wb_bus, 70'd0);
        chk("rst_id_bus", mif.mem_id_bus, 39'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        mif.ex_mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mif.ex_mem_bus = mk(1'b1, 1'b0, 3'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), alu_vals[i]);
            step();
            if (i == 2) mif.ex_mem_valid = 1'b0;
            #3;
            chk("alu_valid", mif.mem_wb_valid, 1'b1);
            chk("alu_res", mif.mem_wb_bus[31:0], alu_vals[i]);
            chk("alu_allowin", mif.mem_allowin, 1'b1);
        end
        step();
        #3 chk("drain_valid", mif.mem_wb_valid, 1'b0);

        mif.ex_mem_valid = 1'b1;
        mif.ex_mem_bus   = mk(1'b1, 1'b1, 3'd1, 5'd7, 32'h200, 32'h0000_1002);
        step();
        mif.ex_mem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            chk("lb_pending", mif.mem_id_bus[37], 1'b1);
            chk("lb_allowin", mif.mem_allowin, 1'b0);
            chk("lb_wait_valid", mif.mem_wb_valid, 1'b0);
            step();
        end
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h1280_3456;
        #3;
        chk("lb_valid", mif.mem_wb_valid, 1'b1);
        chk("lb_res", mif.mem_wb_bus[31:0], 32'hFFFF_FF80);
        chk("lb_allowin_done", mif.mem_allowin, 1'b1);
        step();
        mif.data_sram_data_ok = 1'b0;

        do_load("lhu", 3'd4, 32'h0000_3002, 32'h8001_FFFF, 32'h0000_8001);
        do_load("lh", 3'd2, 32'h0000_3002, 32'h8001_FFFF, 32'hFFFF_8001);
        do_load("lbu", 3'd3, 32'h0000_3001, 32'h1280_3456, 32'h0000_0034);
        do_load("lb0", 3'd1, 32'h0000_3000, 32'h0000_00F0, 32'hFFFF_FFF0);
        do_load("lw6", 3'd6, 32'h0000_3003, 32'hA5A5_1234, 32'hA5A5_1234);

        mif.ex_mem_valid = 1'b1;
        mif.ex_mem_bus   = mk(1'b1, 1'b1, 3'd0, 5'd9, 32'h500, 32'h2000_0003);
        step();
        mif.ex_mem_valid      = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'hCAFE_F00D;
        mif.wb_allowin        = 1'b0;
        hold_bus = {1'b1, 5'd9, 32'h500, 32'hCAFE_F00D};
        #3;
        chk("hold_in_valid", mif.mem_wb_valid, 1'b1);
        chk("hold_in_allowin", mif.mem_allowin, 1'b0);
        step();
        mif.data_sram_data_ok = 1'b0;
        mif.data_sram_rdata   = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("hold_bus", mif.mem_wb_bus, hold_bus);
            chk("hold_id", mif.mem_id_bus, {2'b10, 5'd9, 32'hCAFE_F00D});
            chk("hold_valid", mif.mem_wb_valid, 1'b1);
            step();
        end
        mif.wb_allowin = 1'b1;
        #3;
        chk("hold_rel_allowin", mif.mem_allowin, 1'b1);
        chk("hold_rel_bus", mif.mem_wb_bus, hold_bus);
        step();

        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h5555_AAAA;
        #3;
        chk("stray_valid", mif.mem_wb_valid, 1'b0);
        chk("stray_allowin", mif.mem_allowin, 1'b1);
        chk("stray_flags", mif.mem_id_bus[38:37], 2'b00);
        step();
        mif.data_sram_data_ok = 1'b0;
        #3 chk("stray_after", mif.mem_wb_valid, 1'b0);

        mif.ex_mem_valid = 1'b1;
        mif.ex_mem_bus   = mk(1'b1, 1'b1, 3'd1, 5'd11, 32'h600, 32'h0000_0001);
        step();
        mif.ex_mem_valid = 1'b0;
        #2;
        chk("rw_pending", mif.mem_id_bus[37], 1'b1);
        reset = 1'b1;
        #1;
        chk("rw_valid", mif.mem_wb_valid, 1'b0);
        chk("rw_allowin", mif.mem_allowin, 1'b1);
        chk("rw_id_bus", mif.mem_id_bus, 39'd0);
        chk("rw_wb_bus", mif.mem_wb_bus, 70'd0);
        #3 reset = 1'b0;
        mif.data_sram_data_ok = 1'b1;
        mif.data_sram_rdata   = 32'h1234_5678;
        #1;
        chk("rw_late_ok", mif.mem_wb_valid, 1'b0);
        chk("rw_late_pend", mif.mem_id_bus[37], 1'b0);
        step();
        mif.data_sram_data_ok = 1'b0;
        #3;
        chk("rw_after_valid", mif.mem_wb_valid, 1'b0);
        chk("rw_after_allowin", mif.mem_allowin, 1'b1);
        step();

        for (int c = 0; c < 3000; c++) begin
            mif.ex_mem_valid    = $urandom_range(0, 99) < 60;
            mif.ex_mem_bus      = 74'({$urandom(), $urandom(), $urandom()});
            mif.wb_allowin      = $urandom_range(0, 99) < 70;
            mif.data_sram_rdata = $urandom();
            mif.data_sram_data_ok = (m_v && m_ld && !m_have) ? ($urandom_range(0, 99) < 35)
                                                             : ($urandom_range(0, 99) < 5);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and write-back. It accepts one instruction per handshake from execute and waits for the data-SRAM response when the instruction is a load. It aligns and sign- or zero-extends the loaded byte, half or word, and buffers the response if write-back stalls. It forwards the stage result, with a load-pending flag, back to decode for bypass and stall decisions.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_mem_valid  in  1  execute stage offers an instruction.
- ex_mem_bus  in  74  {gr_we[73], res_from_mem[72], ld_type[71:69], dest[68:64], pc[63:32], alu_result[31:0]}.
- mem_allowin  out  1  stage can accept from execute this cycle.
- data_sram_data_ok  in  1  one-cycle pulse: load data valid on data_sram_rdata.
- data_sram_rdata  in  32  raw word read from address {alu_result[31:2], 2'b00}.
- mem_wb_valid  out  1  stage offers a completed instruction to write-back.
- wb_allowin  in  1  write-back accepts this cycle.
- mem_wb_bus  out  70  {gr_we[69], dest[68:64], pc[63:32], final_result[31:0]}.
- mem_id_bus  out  39  {fwd_valid[38], ld_pending[37], dest[36:32], final_result[31:0]}.

## Operation
- Held state:
  - mem_valid: 1 bit.
  - bus_r: 74-bit latched copy of ex_mem_bus.
  - FSM: PASS, WAIT, HOLD.
  - rdata_buf: 32 bits.
- Accept: when ex_mem_valid & mem_allowin, latch ex_mem_bus into bus_r and set mem_valid.
- Drain: when mem_allowin & ~ex_mem_valid, clear mem_valid.
- Entry state: load (res_from_mem=1) enters WAIT; anything else enters PASS.
- WAIT:
  - data_ok & wb_allowin: instruction retires this cycle with live rdata.
  - data_ok & ~wb_allowin: capture rdata into rdata_buf, go to HOLD.
  - Otherwise stay in WAIT.
- HOLD: stay until wb_allowin; the result uses rdata_buf.
- After retiring: next state follows the newly accepted instruction, or PASS if none is accepted.
- mem_ready_go is 1 in PASS, 1 in HOLD, and data_sram_data_ok in WAIT.
- Handshake outputs:
  - mem_wb_valid = mem_valid & mem_ready_go.
  - mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
- Data source: ld_word is rdata_buf in HOLD, data_sram_rdata otherwise.
- Byte select: byte = ld_word[8*a+7 : 8*a], with a = alu_result[1:0].
- Half select: half = alu_result[1] ? ld_word[31:16] : ld_word[15:0]; alu_result[0] is ignored.
- ld_type decode:
  - 000 word: ld_word; low address bits ignored.
  - 001 signed byte.
  - 010 signed half.
  - 011 unsigned byte.
  - 100 unsigned half.
  - 101-111: treated as word.
- final_result = res_from_mem ? extended load : alu_result.
- Forwarding flags:
  - fwd_valid = mem_valid & gr_we.
  - ld_pending = mem_valid & res_from_mem & ~mem_ready_go; decode must stall while it is set.
- data_sram_data_ok outside WAIT is ignored: no capture, no state change.

## Timing
- Reset asynchronously clears mem_valid, bus_r, rdata_buf and FSM (to PASS).
  - During reset: mem_wb_valid=0, mem_allowin=1, mem_wb_bus=0, mem_id_bus=0.
  - A data_ok arriving after reset deasserts is ignored.
- Non-load latency: accepted at edge N, mem_wb_valid high in cycle N+1.
- Load latency: mem_wb_valid is high in the data_ok cycle; data_ok in cycle N+1 gives zero extra stall.
- Back-to-back: mem_allowin is combinational on wb_allowin, so a new instruction can enter in the same cycle the current one retires.
- HOLD: mem_wb_bus and mem_id_bus stay stable every cycle until wb_allowin.
- At most one load is outstanding; execute must not issue a second load while mem_allowin=0.

## Test plan
- Non-load stream: ALU ops with alu_result 0x11, 0x22, 0x33 on consecutive cycles, wb_allowin=1 -> mem_wb_valid=1 on each following cycle, final_result matches, mem_allowin stays 1.
- Signed byte: ld_type=001, addr low bits 2'b10, rdata 0x12_80_34_56, data_ok 3 cycles later -> final_result 0xFFFFFF80. During the wait: ld_pending=1, mem_allowin=0, mem_wb_valid=0.
- Unsigned half: ld_type=100, addr low bits 2'b10, rdata 0x8001_FFFF -> 0x00008001. Same load with ld_type=010 -> 0xFFFF8001.
- HOLD: data_ok while wb_allowin=0, then rdata changes to 0xDEADBEEF; release wb_allowin after 4 cycles -> retires with the original buffered word, bus stable throughout.
- Stray response: data_ok pulse with no load in the stage -> no state change, no output change.
- Reset mid-WAIT: assert reset -> mem_valid=0 and mem_allowin=1 immediately, without waiting for a clock edge. A data_ok after release -> ignored.
